// File: rtl/fp_mul_pkg.sv
// Shared definitions for the fp_mul_arbiter slice.
//   - flag bit positions inside the 4-bit {ovf, udf, inf, nan} flag word
//   - FP32 field widths
//   - tag carried alongside each in-flight multiply
package fp_mul_pkg;

   localparam int FLAG_OVF = 3;
   localparam int FLAG_UDF = 2;
   localparam int FLAG_INF = 1;
   localparam int FLAG_NAN = 0;
   localparam int FLAG_W   = 4;

   localparam int EXP_WIDTH      = 8;
   localparam int MANTISSA_WIDTH = 23;
   localparam int FP_WIDTH       = 1 + EXP_WIDTH + MANTISSA_WIDTH;

   // Index field sized for the largest supported requester count (8).
   localparam int TAG_IDX_W = 3;

   typedef struct packed {
      logic                 valid;
      logic [TAG_IDX_W-1:0] index;
   } tag_t;

endpackage

// File: rtl/fp_mul_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over N requesters.
//   clk, rst  : clock, async active-high reset
//   req[N]    : eligible requesters
//   advance   : a grant was taken this cycle; move ptr past the winner
//   grant[N]  : combinational one-hot grant, zero when req is zero
// The search starts at ptr; after a taken grant to i, ptr becomes (i+1) mod N.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_nxt;
   logic [PW-1:0] idx;
   logic [PW:0]   sum;
   logic [PW:0]   nxt;
   logic          found;

   always_comb begin
      grant   = '0;
      ptr_nxt = ptr;
      found   = 1'b0;
      idx     = '0;
      sum     = '0;
      nxt     = '0;
      for (int off = 0; off < N; off++) begin
         // (ptr + off) mod N without a divider: one conditional subtract
         sum = {1'b0, ptr} + (PW+1)'(off);
         if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
         idx = sum[PW-1:0];
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            nxt        = {1'b0, idx} + (PW+1)'(1);
            ptr_nxt    = (nxt == (PW+1)'(N)) ? '0 : nxt[PW-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          ptr <= '0;
      else if (advance) ptr <= ptr_nxt;
   end

endmodule

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: shares one pipelined FP32 multiplier among NUM_REQ requesters.
//   req_valid/req_ready/req_a/req_b : per-requester operand handshake (ready = one-hot grant)
//   mul_valid/mul_a/mul_b           : registered issue to the multiplier
//   mul_result/mul_flags            : multiplier output, MUL_LATENCY cycles after mul_valid
//   rsp_valid/rsp_ready/rsp_result/rsp_flags : per-requester one-entry response buffer
//   busy                            : requester has an operation in flight or buffered
// Each requester has at most one outstanding op, so its response buffer can never overflow.
module fp_mul_arbiter
   import fp_mul_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int MUL_LATENCY = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [FP_WIDTH*NUM_REQ-1:0] req_a,
   input  logic [FP_WIDTH*NUM_REQ-1:0] req_b,
   output logic                        mul_valid,
   output logic [FP_WIDTH-1:0]         mul_a,
   output logic [FP_WIDTH-1:0]         mul_b,
   input  logic [FP_WIDTH-1:0]         mul_result,
   input  logic [FLAG_W-1:0]           mul_flags,
   output logic [NUM_REQ-1:0]          rsp_valid,
   input  logic [NUM_REQ-1:0]          rsp_ready,
   output logic [FP_WIDTH*NUM_REQ-1:0] rsp_result,
   output logic [FLAG_W*NUM_REQ-1:0]   rsp_flags,
   output logic [NUM_REQ-1:0]          busy
);

   logic [NUM_REQ-1:0]   eligible;
   logic [NUM_REQ-1:0]   grant;
   logic                 issue;
   logic [TAG_IDX_W-1:0] grant_idx;
   logic [FP_WIDTH-1:0]  sel_a;
   logic [FP_WIDTH-1:0]  sel_b;
   tag_t                 tag_pipe [MUL_LATENCY+1];
   tag_t                 ret_tag;

   // Gating with rst keeps req_ready low while reset is held.
   assign eligible  = req_valid & ~busy & {NUM_REQ{~rst}};
   assign issue     = |grant;
   assign req_ready = grant;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (eligible),
      .advance (issue),
      .grant   (grant)
   );

   always_comb begin
      grant_idx = '0;
      sel_a     = '0;
      sel_b     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            grant_idx = TAG_IDX_W'(i);
            sel_a     = req_a[FP_WIDTH*i +: FP_WIDTH];
            sel_b     = req_b[FP_WIDTH*i +: FP_WIDTH];
         end
      end
   end

   // tag_pipe[0] is the issue stage and lines up with mul_valid; the result
   // arrives MUL_LATENCY cycles later, when the tag reaches tag_pipe[MUL_LATENCY].
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_a <= '0;
         mul_b <= '0;
         for (int s = 0; s <= MUL_LATENCY; s++) tag_pipe[s] <= '0;
      end else begin
         tag_pipe[0] <= '{valid: issue, index: grant_idx};
         for (int s = 1; s <= MUL_LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
         if (issue) begin
            mul_a <= sel_a;
            mul_b <= sel_b;
         end
      end
   end

   assign mul_valid = tag_pipe[0].valid;
   assign ret_tag   = tag_pipe[MUL_LATENCY];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      logic                retire;
      logic                consume;
      logic                v_q;
      logic                b_q;
      logic [FP_WIDTH-1:0] r_q;
      logic [FLAG_W-1:0]   f_q;

      assign retire  = ret_tag.valid && (ret_tag.index == TAG_IDX_W'(i));
      assign consume = v_q & rsp_ready[i];

      // Grant and consume never hit the same requester in one cycle (busy
      // blocks the grant), nor do retire and consume (buffer empty on retire).
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_q <= 1'b0;
            b_q <= 1'b0;
            r_q <= '0;
            f_q <= '0;
         end else begin
            if (grant[i])     b_q <= 1'b1;
            else if (consume) b_q <= 1'b0;
            if (retire) begin
               v_q <= 1'b1;
               r_q <= mul_result;
               f_q <= mul_flags;
            end else if (consume) begin
               v_q <= 1'b0;
            end
         end
      end

      assign rsp_valid[i]                        = v_q;
      assign busy[i]                             = b_q;
      assign rsp_result[FP_WIDTH*i +: FP_WIDTH] = r_q;
      assign rsp_flags[FLAG_W*i +: FLAG_W]      = f_q;
   end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench for fp_mul_arbiter with a stub pipelined multiplier and
// a transaction-level reference model (round-robin pointer, per-requester
// grant time, expected response).
module tb_fp_mul_arbiter;
   localparam int NR = 4;
   localparam int L  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NR-1:0]    req_valid = '0, req_ready, rsp_valid, rsp_ready = '0, busy;
   logic [32*NR-1:0] req_a = '0, req_b = '0, rsp_result;
   logic [4*NR-1:0]  rsp_flags;
   logic             mul_valid;
   logic [31:0]      mul_a, mul_b, mul_result;
   logic [3:0]       mul_flags;

   int n_chk = 0, n_fail = 0;

   // reference model state
   int            cyc;
   int            ptr_m;
   logic [NR-1:0] busy_m;
   int            gcyc [NR];
   logic [35:0]   exp_m [NR];
   logic          iss_v;
   logic [31:0]   iss_a, iss_b;
   int            glog[$];
   int            gclog[$];

   always #5 clk = ~clk;

   fp_mul_arbiter #(.NUM_REQ(NR), .MUL_LATENCY(L)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
      .mul_result(mul_result), .mul_flags(mul_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
   );

   // Stub multiplier: {flags, result}. Two fixed cases match the test plan,
   // anything else gets a scrambled but deterministic value.
   function automatic logic [35:0] stub_mul(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h4000_0000 && b == 32'h4040_0000) return {4'b0000, 32'h40C0_0000};
      if (a == 32'h7F00_0000 && b == 32'h7F00_0000) return {4'b1010, 32'h7F80_0000};
      return {a[3:0] ^ b[7:4], a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0001};
   endfunction

   // Idle stages carry garbage so a stray capture would show up.
   logic [35:0] sp [L];
   always @(posedge clk) begin
      sp[0] <= mul_valid ? stub_mul(mul_a, mul_b) : {4'($urandom), 32'($urandom)};
      for (int j = 1; j < L; j++) sp[j] <= sp[j-1];
   end
   assign {mul_flags, mul_result} = sp[L-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b);
      req_a[32*k +: 32] = a;
      req_b[32*k +: 32] = b;
   endtask

   task automatic rand_ops();
      for (int k = 0; k < NR; k++) set_op(k, $urandom, $urandom);
   endtask

   task automatic model_reset();
      ptr_m  = 0;
      busy_m = '0;
      iss_v  = 1'b0;
      cyc    = 0;
      for (int k = 0; k < NR; k++) gcyc[k] = 0;
   endtask

   // One clock cycle: inputs are already applied (at the negedge); check all
   // outputs against the model, take the edge, update the model.
   task automatic cycle();
      logic [NR-1:0] g, erv;
      int gi, k;
      #1;
      g = '0; gi = -1;
      for (int off = 0; off < NR; off++) begin
         k = (ptr_m + off) % NR;
         if (gi < 0 && req_valid[k] && !busy_m[k]) gi = k;
      end
      if (gi >= 0) g[gi] = 1'b1;
      erv = '0;
      for (int r = 0; r < NR; r++) erv[r] = busy_m[r] && (cyc >= gcyc[r] + L + 2);
      chk("req_ready", 32'(req_ready), 32'(g));
      chk("mul_valid", 32'(mul_valid), 32'(iss_v));
      if (iss_v) begin
         chk("mul_a", mul_a, iss_a);
         chk("mul_b", mul_b, iss_b);
      end
      chk("busy", 32'(busy), 32'(busy_m));
      chk("rsp_valid", 32'(rsp_valid), 32'(erv));
      for (int r = 0; r < NR; r++) if (erv[r]) begin
         chk("rsp_result", rsp_result[32*r +: 32], exp_m[r][31:0]);
         chk("rsp_flags", 32'(rsp_flags[4*r +: 4]), 32'(exp_m[r][35:32]));
      end
      @(posedge clk);
      iss_v = (gi >= 0);
      if (gi >= 0) begin
         iss_a     = req_a[32*gi +: 32];
         iss_b     = req_b[32*gi +: 32];
         exp_m[gi] = stub_mul(iss_a, iss_b);
         busy_m[gi] = 1'b1;
         gcyc[gi]  = cyc;
         ptr_m     = (gi + 1) % NR;
         glog.push_back(gi);
         gclog.push_back(cyc);
      end
      for (int r = 0; r < NR; r++) if (erv[r] && rsp_ready[r]) busy_m[r] = 1'b0;
      cyc++;
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      #1;
      chk({tag, ".req_ready"}, 32'(req_ready), 32'h0);
      chk({tag, ".mul_valid"}, 32'(mul_valid), 32'h0);
      chk({tag, ".mul_a"}, mul_a, 32'h0);
      chk({tag, ".mul_b"}, mul_b, 32'h0);
      chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'h0);
      chk({tag, ".busy"}, 32'(busy), 32'h0);
      for (int r = 0; r < NR; r++) begin
         chk({tag, ".rsp_result"}, rsp_result[32*r +: 32], 32'h0);
         chk({tag, ".rsp_flags"}, 32'(rsp_flags[4*r +: 4]), 32'h0);
      end
   endtask

   task automatic drain();
      req_valid = '0;
      rsp_ready = '1;
      repeat (L + 4) cycle();
   endtask

   initial begin
      int n, cnt;

      // ---- reset values (req_valid high to show ready stays low) ----
      cyc = 0;
      rst = 1'b1;
      req_valid = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      req_valid = '0;
      model_reset();

      // ---- single request: 2.0 * 3.0 ----
      rsp_ready = '1;
      req_valid = 4'b0001;
      set_op(0, 32'h4000_0000, 32'h4040_0000);
      #1;
      chk("single.req_ready_c0", 32'(req_ready), 32'h1);
      cycle();
      req_valid = '0;
      #1;
      chk("single.mul_valid_c1", 32'(mul_valid), 32'h1);
      repeat (4) cycle();
      #1;
      chk("single.rsp_valid_c5", 32'(rsp_valid[0]), 32'h1);
      chk("single.rsp_result", rsp_result[31:0], 32'h40C0_0000);
      chk("single.rsp_flags", 32'(rsp_flags[3:0]), 32'h0);
      cycle();

      // ---- fairness: all valid, responses consumed at once ----
      glog.delete(); gclog.delete();
      req_valid = '1;
      rsp_ready = '1;
      repeat (40) begin rand_ops(); cycle(); end
      chk("fair.grant_count_ge_20", 32'(glog.size() >= 20), 32'h1);
      for (int i = 1; i < glog.size(); i++)
         chk("fair.order", 32'(glog[i]), 32'((glog[i-1] + 1) % NR));

      // ---- response stall on requester 2 ----
      rsp_ready = 4'b1011;
      n = 0;
      while (!busy_m[2] && n < 20) begin rand_ops(); cycle(); n++; end
      chk("stall.req2_granted", 32'(busy_m[2]), 32'h1);
      glog.delete(); gclog.delete();
      repeat (20) begin
         rand_ops();
         cycle();
         #1;
         chk("stall.busy2_noready2", {30'h0, busy[2], req_ready[2]}, 32'h2);
      end
      cnt = 0;
      foreach (glog[i]) if (glog[i] != 2) cnt++;
      chk("stall.others_issue", 32'(cnt >= 5), 32'h1);
      rsp_ready = '1;
      cycle();
      #1;
      chk("stall.busy2_cleared", 32'(busy[2]), 32'h0);

      // ---- flag passthrough on requester 1 ----
      drain();
      req_valid = 4'b0010;
      set_op(1, 32'h7F00_0000, 32'h7F00_0000);
      rsp_ready = '0;
      n = 0;
      while (n < 15) begin
         #1;
         if (rsp_valid[1]) break;
         cycle();
         req_valid = '0;
         n++;
      end
      chk("flags.rsp_valid1_seen", 32'(rsp_valid[1]), 32'h1);
      chk("flags.rsp_result1", rsp_result[63:32], 32'h7F80_0000);
      chk("flags.rsp_flags1", 32'(rsp_flags[7:4]), 32'ha);
      rsp_ready = '1;
      cycle();

      // ---- back-to-back reuse of requester 0 ----
      drain();
      glog.delete(); gclog.delete();
      req_valid = 4'b0001;
      rsp_ready = '1;
      repeat (30) begin rand_ops(); cycle(); end
      chk("b2b.grants_ge_3", 32'(gclog.size() >= 3), 32'h1);
      for (int i = 1; i < gclog.size(); i++)
         chk("b2b.spacing", 32'(gclog[i] - gclog[i-1]), 32'(L + 3));

      // ---- reset mid-flight: issue to 0 and 3, reset at cycle 2 ----
      drain();
      req_valid = 4'b1001;
      rsp_ready = '1;
      rand_ops();
      cycle();
      cycle();
      rst = 1'b1;
      chk_reset_outputs("midrst");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      req_valid = '0;
      model_reset();
      repeat (12) begin
         cycle();
         #1;
         chk("midrst.no_rsp", 32'(rsp_valid), 32'h0);
      end
      req_valid = '1;
      #1;
      chk("midrst.ptr_zero", 32'(req_ready), 32'h1);
      cycle();

      // ---- random traffic ----
      repeat (300) begin
         req_valid = NR'($urandom);
         rsp_ready = NR'($urandom);
         rand_ops();
         cycle();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Hard stop in case a wait above is broken.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Shares one pipelined `fp_multiplier` instance among `NUM_REQ` requesters using round-robin arbitration. The block accepts operand pairs over per-requester valid/ready handshakes and issues at most one operation per cycle to the multiplier. A tag pipeline tracks each in-flight operation. Each result and its exception flags return to the originating requester through a one-entry response buffer.

## Interface
- `NUM_REQ`, 4: number of requesters; 2..8.
- `MUL_LATENCY`, 3: cycles from `mul_valid` to `mul_result` valid; ≥1.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: requester i has an operand pair.
- `req_ready` out NUM_REQ: one-hot grant; handshake when `req_valid[i] & req_ready[i]`.
- `req_a` in 32*NUM_REQ: IEEE-754 single operand A; slice i is `[32i+31:32i]`.
- `req_b` in 32*NUM_REQ: operand B, same packing.
- `mul_valid` out 1: issue strobe to the multiplier.
- `mul_a`, `mul_b` out 32: registered operands to the multiplier.
- `mul_result` in 32: multiplier product.
- `mul_flags` in 4: {overflow, underflow, inf, nan} from the multiplier, aligned with `mul_result`.
- `rsp_valid` out NUM_REQ: response buffer i holds a result.
- `rsp_ready` in NUM_REQ: requester i consumes its response.
- `rsp_result` out 32*NUM_REQ: per-requester result, same packing as `req_a`.
- `rsp_flags` out 4*NUM_REQ: per-requester flags.
- `busy` out NUM_REQ: requester i has an operation in flight or buffered.

## Operation
- **Eligibility:** eligible[i] = `req_valid[i] & ~busy[i]`. Each requester may have at most one outstanding operation, so response buffers never overflow.
- **Arbitration:**
  - Round-robin over eligible requesters. The search starts at `ptr`.
  - `req_ready` is the combinational one-hot grant. It is all-zero when no requester is eligible.
  - On a grant to i, `ptr` becomes (i+1) mod NUM_REQ. With no grant, `ptr` holds.
- **Issue:**
  - On a grant, the operands of i are registered into `mul_a`/`mul_b`, and `mul_valid`=1 for one cycle.
  - `busy[i]` is set.
  - The tag pipeline (depth MUL_LATENCY, entries {valid, index[$clog2(NUM_REQ)-1:0]}) shifts every cycle.
- **Retire:**
  - When the tag pipeline output is valid with index k, `mul_result`/`mul_flags` are written into response buffer k.
  - `rsp_valid[k]` is set on the following edge.
- **Consume:**
  - On `rsp_valid[k] & rsp_ready[k]`, the block clears `rsp_valid[k]` and `busy[k]`.
  - There is no bypass: requester k can be re-granted no earlier than the cycle after the response handshake.
- **Holding:** `rsp_result`/`rsp_flags` for k hold their value while `rsp_valid[k]`=1 and stay stable until the handshake.
- **Operand handling:** the block does not inspect operand contents. NaN/inf handling belongs to the multiplier; flags pass through unchanged.

## Timing
- **Reset values:** `req_ready`=0, `mul_valid`=0, `mul_a`=`mul_b`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_flags`=0, `busy`=0, `ptr`=0, all tag valids=0.
- **Latency:** grant edge t → `mul_valid` at t+1 → result captured at t+1+MUL_LATENCY → `rsp_valid` high from t+2+MUL_LATENCY. Total from request handshake to response: MUL_LATENCY+2 cycles.
- **Throughput:** one issue per cycle across all requesters. Per requester, at most one operation per MUL_LATENCY+3 cycles (including the response handshake cycle).
- **Simultaneous retire and grant:** legal. The retiring requester is still busy that cycle.
- **Response stall:** `rsp_ready` held low keeps `busy` set. Other requesters continue unaffected.
- **Reset mid-operation:** all in-flight tags and buffered responses are discarded, and no response is produced for them. The block ignores `mul_result` until its next issue.
- **Pointer wrap-around:** NUM_REQ-1 wraps to 0.

## Structure
- Package `fp_mul_pkg` holds:
  - flag bit positions (FLAG_OVF=3, FLAG_UDF=2, FLAG_INF=1, FLAG_NAN=0);
  - the FP32 field widths (EXP_WIDTH=8, MANTISSA_WIDTH=23);
  - a tag struct {valid, index}.
- Sub-module `rr_arbiter`: parameter N; inputs `clk`, `rst`, `req[N]`, `advance`; output `grant[N]`. It owns `ptr`. The tag pipeline, issue registers and response buffers live in `fp_mul_arbiter`.

## Test plan
- **Single request:** after reset, `req_valid[0]`=1, a=0x40000000 (2.0), b=0x40400000 (3.0); stub multiplier with latency 3 → `req_ready[0]` in cycle 0, `mul_valid` at cycle 1, `rsp_valid[0]` at cycle 5 with 0x40C00000 (6.0), flags 0.
- **Fairness:** all four requesters valid continuously and responses consumed immediately → grants in order 0,1,2,3,0…. No requester is granted twice before every eligible requester has been granted once.
- **Response stall:** hold `rsp_ready[2]`=0 for 20 cycles → `busy[2]`=1 and `req_ready[2]`=0 throughout. Requesters 0, 1 and 3 keep issuing. On release, `busy[2]` clears on the next edge.
- **Flag passthrough:** the stub returns 0x7F800000 with flags 4'b1010 for requester 1 → `rsp_result[1]`=0x7F800000, `rsp_flags[1]`=4'b1010.
- **Reset mid-flight:** issue to requesters 0 and 3, then assert `rst` at cycle 2 → all outputs return to their reset values. No `rsp_valid` is ever asserted for those operations.
- **Back-to-back reuse:** requester 0 is re-granted no earlier than the cycle after its response handshake. With `rsp_ready` tied high, its second grant follows its first by MUL_LATENCY+3 cycles.
